// File: rtl/bram_copy_ctrl.sv
// bram_copy_ctrl
// Copies len words from a source BRAM port to a destination BRAM port.
// One read is issued per cycle. Each word is written to the destination one
// cycle later, straight from the source read data, so there is no buffering.
//
// Ports
//   BRAM_CLK, BRAM_RST        clock, asynchronous active-low reset
//   start                     copy request, sampled only in IDLE
//   src_base, dst_base, len   copy parameters, latched when start is accepted
//   busy, done                busy over the copy, one-cycle done pulse in FIN
//   SRC_ADDR/EN/WE/RDDATA     source BRAM port (read only)
//   DST_ADDR/EN/WE/WRDATA     destination BRAM port (write only)
//   checksum                  present only when BRAM_COPY_CHECKSUM_EN is defined
//
// Optional feature macro: BRAM_COPY_CHECKSUM_EN
//
// state | meaning
// IDLE  | waiting for start
// COPY  | issuing one source read per cycle
// DRAIN | writing the last word read in COPY
// FIN   | done pulse, then back to IDLE
module bram_copy_ctrl #(
    parameter int BITWIDTH  = 32,
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 8192
) (
    input  logic                BRAM_CLK,
    input  logic                BRAM_RST,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [13:0]         len,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   SRC_ADDR,
    output logic                SRC_EN,
    output logic [3:0]          SRC_WE,
    input  logic [BITWIDTH-1:0] SRC_RDDATA,
    output logic [ADDR_W-1:0]   DST_ADDR,
    output logic                DST_EN,
    output logic [3:0]          DST_WE,
    output logic [BITWIDTH-1:0] DST_WRDATA
`ifdef BRAM_COPY_CHECKSUM_EN
    ,
    output logic [BITWIDTH-1:0] checksum
`endif
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {IDLE, COPY, DRAIN, FIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rd_left;
    logic [CNT_W-1:0]  len_sat;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_active;
    logic              start_acc;

    assign start_acc = (state == IDLE) && start;

    always_comb begin
        len_sat = CNT_W'(len);
        if (32'(len) > MAX_WORDS)
            len_sat = CNT_W'(MAX_WORDS);
    end

    // state register
    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len_sat == '0) ? FIN : COPY;
            COPY:    if (rd_left == CNT_W'(1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read counter/addresses. The write side trails the read side by exactly
    // one cycle, so wr_active is simply "we were in COPY last cycle".
    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST) begin
            rd_left   <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_active <= 1'b0;
        end else begin
            wr_active <= (state == COPY);
            if (start_acc) begin
                rd_left <= len_sat;
                rd_addr <= src_base & ALIGN_MASK;
                wr_addr <= dst_base & ALIGN_MASK;
            end else begin
                if (state == COPY) begin
                    rd_left <= rd_left - CNT_W'(1);
                    rd_addr <= rd_addr + WORD_STEP;
                end
                if (wr_active)
                    wr_addr <= wr_addr + WORD_STEP;
            end
        end
    end

    // outputs; all gated by state so reset zeroes them immediately
    always_comb begin
        busy       = (state == COPY) || (state == DRAIN);
        done       = (state == FIN);
        SRC_EN     = (state == COPY);
        SRC_WE     = 4'b0000;
        SRC_ADDR   = SRC_EN ? rd_addr : '0;
        DST_EN     = wr_active;
        DST_WE     = wr_active ? 4'b1111 : 4'b0000;
        DST_ADDR   = wr_active ? wr_addr : '0;
        DST_WRDATA = wr_active ? SRC_RDDATA : '0;
    end

`ifdef BRAM_COPY_CHECKSUM_EN
    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST)
            checksum <= '0;
        else if (start_acc)
            checksum <= '0;
        else if (wr_active)
            checksum <= checksum + SRC_RDDATA;
    end
`endif

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// Directed testbench for bram_copy_ctrl with behavioural source/destination BRAMs.
module tb_bram_copy_ctrl;
    localparam int AW = 15;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [13:0]   len = '0;
    logic          busy, done;
    logic [AW-1:0] SRC_ADDR, DST_ADDR;
    logic          SRC_EN, DST_EN;
    logic [3:0]    SRC_WE, DST_WE;
    logic [31:0]   SRC_RDDATA, DST_WRDATA;
`ifdef BRAM_COPY_CHECKSUM_EN
    logic [31:0]   checksum;
    logic [31:0]   m_cks;
`endif

    logic [31:0] src_mem [8192];
    logic [31:0] dst_mem [8192];
    logic        dst_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int m_done_cyc, m_done_cnt, m_busy_first, m_busy_last, m_busy_cnt;
    int m_src_err, m_dst_err, m_nrd, m_nwr;

    always #5 clk = ~clk;

    bram_copy_ctrl #(.BITWIDTH(32), .ADDR_W(AW), .MAX_WORDS(8192)) dut (
        .BRAM_CLK(clk), .BRAM_RST(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done),
        .SRC_ADDR(SRC_ADDR), .SRC_EN(SRC_EN), .SRC_WE(SRC_WE), .SRC_RDDATA(SRC_RDDATA),
        .DST_ADDR(DST_ADDR), .DST_EN(DST_EN), .DST_WE(DST_WE), .DST_WRDATA(DST_WRDATA)
`ifdef BRAM_COPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always @(posedge clk) begin
        if (SRC_EN)
            SRC_RDDATA <= src_mem[SRC_ADDR[AW-1:2]];
        if (dst_clr) begin
            for (int i = 0; i < 8192; i++) dst_mem[i] <= SENT;
        end else if (DST_EN && DST_WE == 4'hF) begin
            dst_mem[DST_ADDR[AW-1:2]] <= DST_WRDATA;
        end
    end

    task automatic clear_dst();
        @(negedge clk); dst_clr = 1'b1;
        @(negedge clk); dst_clr = 1'b0;
    endtask

    // Starts a copy and watches ncyc cycles against the expected read/write
    // windows; start is re-pulsed in cycle 'repulse' (0 = never).
    task automatic run_copy(input logic [AW-1:0] sb, input logic [AW-1:0] db,
                            input logic [13:0] ln, input int ncyc, input int repulse);
        int n, sbase, dbase;
        logic exp_rd, exp_wr;
        logic [AW-1:0] ea, sa, da;
        n = (ln > 14'd8192) ? 8192 : int'(ln);
        sbase = int'(sb) & ~3;
        dbase = int'(db) & ~3;
        m_done_cyc = -1; m_done_cnt = 0; m_busy_first = -1; m_busy_last = -1;
        m_busy_cnt = 0; m_src_err = 0; m_dst_err = 0; m_nrd = 0; m_nwr = 0;
        @(negedge clk);
        src_base = sb; dst_base = db; len = ln; start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = (k == repulse);
            if (k == 2) begin
                src_base = ~sb; dst_base = ~db; len = 14'd3;
            end
            if (busy) begin
                m_busy_cnt++;
                if (m_busy_first < 0) m_busy_first = k;
                m_busy_last = k;
            end
            if (done) begin
                m_done_cnt++;
                if (m_done_cyc < 0) m_done_cyc = k;
`ifdef BRAM_COPY_CHECKSUM_EN
                m_cks = checksum;
`endif
            end
            exp_rd = (k <= n);
            exp_wr = (k >= 2) && (k <= n + 1);
            ea = AW'(sbase + 4 * (k - 1));
            sa = AW'(sbase + 4 * (k - 2));
            da = AW'(dbase + 4 * (k - 2));
            if (SRC_EN) m_nrd++;
            if (DST_EN) m_nwr++;
            if (SRC_EN !== exp_rd || SRC_WE !== 4'h0 || SRC_ADDR !== (exp_rd ? ea : AW'(0)))
                m_src_err++;
            if (exp_wr) begin
                if (DST_EN !== 1'b1 || DST_WE !== 4'hF || DST_ADDR !== da ||
                    DST_WRDATA !== src_mem[sa[AW-1:2]])
                    m_dst_err++;
            end else if (DST_EN !== 1'b0 || DST_WE !== 4'h0 || DST_ADDR !== AW'(0)) begin
                m_dst_err++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_status: got %b want 00", {busy, done});
        else n_pass++;
        n_checks++;
        if ({SRC_EN, SRC_ADDR, SRC_WE} !== '0) $display("FAIL reset_src: got en=%b addr=%h want 0", SRC_EN, SRC_ADDR);
        else n_pass++;
        n_checks++;
        if ({DST_EN, DST_WE, DST_ADDR, DST_WRDATA} !== '0) $display("FAIL reset_dst: got en=%b we=%h addr=%h want 0", DST_EN, DST_WE, DST_ADDR);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_full_copy();
        int bad;
        clear_dst();
        run_copy('0, '0, 14'd8192, 8196, 0);
        n_checks++;
        if (m_done_cyc !== 8194 || m_done_cnt !== 1) $display("FAIL full_done: got cycle %0d count %0d want 8194/1", m_done_cyc, m_done_cnt);
        else n_pass++;
        n_checks++;
        if (m_busy_first !== 1 || m_busy_last !== 8193 || m_busy_cnt !== 8193)
            $display("FAIL full_busy: got %0d..%0d (%0d) want 1..8193", m_busy_first, m_busy_last, m_busy_cnt);
        else n_pass++;
        n_checks++;
        if (m_src_err !== 0 || m_dst_err !== 0) $display("FAIL full_ports: got src_err %0d dst_err %0d want 0", m_src_err, m_dst_err);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 8192; i++) if (dst_mem[i] !== 32'(i)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL full_data: got %0d bad words want 0", bad);
        else n_pass++;
    endtask

    task automatic test_len_zero();
        run_copy(15'h0040, 15'h0080, 14'd0, 5, 0);
        n_checks++;
        if (m_done_cyc !== 1 || m_done_cnt !== 1) $display("FAIL zero_done: got cycle %0d count %0d want 1/1", m_done_cyc, m_done_cnt);
        else n_pass++;
        n_checks++;
        if (m_busy_cnt !== 0 || m_nrd !== 0 || m_nwr !== 0)
            $display("FAIL zero_idle: got busy %0d reads %0d writes %0d want 0", m_busy_cnt, m_nrd, m_nwr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        clear_dst();
        run_copy(15'h7FF8, 15'h7FFC, 14'd4, 8, 0);
        n_checks++;
        if (m_src_err !== 0 || m_nrd !== 4) $display("FAIL wrap_src: got err %0d reads %0d want 0/4", m_src_err, m_nrd);
        else n_pass++;
        n_checks++;
        if (m_dst_err !== 0 || m_done_cyc !== 6) $display("FAIL wrap_dst: got err %0d done %0d want 0/6", m_dst_err, m_done_cyc);
        else n_pass++;
        n_checks++;
        if (dst_mem[8191] !== 32'h1FFE || dst_mem[0] !== 32'h1FFF || dst_mem[2] !== 32'h1)
            $display("FAIL wrap_data: got %h %h %h want 00001ffe 00001fff 00000001", dst_mem[8191], dst_mem[0], dst_mem[2]);
        else n_pass++;
    endtask

    task automatic test_restart_ignored();
        run_copy(15'h0100, 15'h0200, 14'd10, 16, 3);
        n_checks++;
        if (m_nwr !== 10 || m_dst_err !== 0) $display("FAIL restart_writes: got %0d err %0d want 10/0", m_nwr, m_dst_err);
        else n_pass++;
        n_checks++;
        if (m_done_cnt !== 1 || m_done_cyc !== 12) $display("FAIL restart_done: got count %0d cycle %0d want 1/12", m_done_cnt, m_done_cyc);
        else n_pass++;
    endtask

    task automatic test_saturate();
        run_copy('0, 15'h0010, 14'h3FFF, 8196, 0);
        n_checks++;
        if (m_done_cyc !== 8194 || m_nrd !== 8192 || m_src_err !== 0)
            $display("FAIL saturate: got done %0d reads %0d err %0d want 8194/8192/0", m_done_cyc, m_nrd, m_src_err);
        else n_pass++;
    endtask

    task automatic test_start_held();
        logic [10:0] bmask, dmask;
        bmask = '0; dmask = '0;
        @(negedge clk);
        src_base = '0; dst_base = 15'h0400; len = 14'd2; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bmask[k] = busy;
            dmask[k] = done;
        end
        start = 1'b0;
        n_checks++;
        if (bmask !== 11'h1CE) $display("FAIL held_busy: got %h want 1ce", bmask);
        else n_pass++;
        n_checks++;
        if (dmask !== 11'h210) $display("FAIL held_done: got %h want 210", dmask);
        else n_pass++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad;
        clear_dst();
        @(negedge clk);
        src_base = '0; dst_base = '0; len = 14'd100; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, SRC_EN, DST_EN, DST_WE, SRC_ADDR, DST_ADDR, DST_WRDATA} !== '0)
            $display("FAIL midrst_out: got busy %b src_en %b dst_en %b dst_we %h want 0", busy, SRC_EN, DST_EN, DST_WE);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dst_mem[0] !== 32'd0 || dst_mem[1] !== 32'd1 || dst_mem[2] !== 32'd2)
            $display("FAIL midrst_head: got %h %h %h want 0 1 2", dst_mem[0], dst_mem[1], dst_mem[2]);
        else n_pass++;
        bad = 0;
        for (int i = 4; i < 8192; i++) if (dst_mem[i] !== SENT) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL midrst_tail: got %0d written words want 0", bad);
        else n_pass++;
        rst_n = 1'b1; len = 14'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || SRC_EN !== 1'b1) $display("FAIL first_start: got busy %b src_en %b want 1 1", busy, SRC_EN);
        else n_pass++;
        repeat (5) @(negedge clk);
    endtask

`ifdef BRAM_COPY_CHECKSUM_EN
    task automatic test_checksum();
        src_mem[16] = 32'd1; src_mem[17] = 32'd2; src_mem[18] = 32'd3; src_mem[19] = 32'hFFFF_FFFF;
        run_copy(15'h0040, 15'h0400, 14'd4, 8, 0);
        n_checks++;
        if (m_cks !== 32'h5) $display("FAIL checksum_done: got %h want 00000005", m_cks);
        else n_pass++;
        n_checks++;
        if (checksum !== 32'h5) $display("FAIL checksum_hold: got %h want 00000005", checksum);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 8192; i++) src_mem[i] = 32'(i);
        test_reset();
        test_full_copy();
        test_len_zero();
        test_wrap();
        test_restart_ignored();
        test_saturate();
        test_start_held();
        test_reset_mid();
`ifdef BRAM_COPY_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bram_copy_ctrl.md
BRAM_COPY_CTRL -- requirements
Module: bram_copy_ctrl

Interface
REQ-001 SHALL: parameter BITWIDTH, default 32, data word width in bits.
REQ-002 SHALL: parameter ADDR_W, default 15, BRAM byte-address width.
REQ-003 SHALL: parameter MAX_WORDS, default 8192, largest transfer length in words.
REQ-004 SHALL: one clock and one reset; reset is asynchronous and active-low.
REQ-005 SHALL: BRAM_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL: BRAM_RST  in  1  asynchronous reset, active-low (0 = reset).
REQ-007 SHALL: start  in  1  request a copy; sampled only in IDLE.
REQ-008 SHALL: src_base  in  ADDR_W  source byte base address; bits [1:0] ignored.
REQ-009 SHALL: dst_base  in  ADDR_W  destination byte base address; bits [1:0] ignored.
REQ-010 SHALL: len  in  14  transfer length in words.
REQ-011 SHALL: busy  out  1  high while a copy is in progress.
REQ-012 SHALL: done  out  1  one-cycle pulse when a copy completes.
REQ-013 SHALL: SRC_ADDR / SRC_EN / SRC_WE  out  ADDR_W / 1 / 4  source BRAM port; SRC_WE is constant 4'b0000.
REQ-014 SHALL: SRC_RDDATA  in  BITWIDTH  source BRAM read data, valid one cycle after an enabled read.
REQ-015 SHALL: DST_ADDR / DST_EN / DST_WE / DST_WRDATA  out  ADDR_W / 1 / 4 / BITWIDTH  destination BRAM port.

Function
REQ-016 SHALL: states IDLE, COPY, DRAIN, FIN; IDLE->COPY on start with len!=0; IDLE->FIN on start with len==0; COPY->DRAIN after last read issued; DRAIN->FIN; FIN->IDLE.
REQ-017 SHALL: latch src_base, dst_base and len on start acceptance; later input changes ignored until IDLE.
REQ-018 SHALL: len above MAX_WORDS saturate to MAX_WORDS.
REQ-019 SHALL: take the start edge as cycle 0; cycles 1..N (COPY) drive SRC_EN=1, SRC_ADDR=src_base+4*(k-1).
REQ-020 SHALL: in cycles 2..N+1, drive DST_EN=1, DST_WE=4'b1111, DST_ADDR=dst_base+4*(k-2), DST_WRDATA=SRC_RDDATA combinationally.
REQ-021 SHALL: outside those windows, hold SRC_EN=0, DST_EN=0, DST_WE=4'b0000 and SRC_ADDR/DST_ADDR at 0.
REQ-022 SHALL: address arithmetic be modulo 2^ADDR_W (wrap past top of BRAM to 0).
REQ-023 SHALL: busy=1 in cycles 1..N+1; done=1 only in cycle N+2 (FIN); the len==0 case gives done in cycle 1 with no BRAM access.
REQ-024 SHALL: start asserted while not IDLE be ignored, neither queued nor restarting.
REQ-025 SHALL: start held high continuously begin a new copy in the cycle following FIN.

Reset
REQ-026 SHALL: BRAM_RST=0 force state IDLE and all outputs to 0 immediately, including mid-copy; no further DST write occurs.
REQ-027 SHALL: after reset release, first start accept at the first rising edge with BRAM_RST=1.

Configuration
REQ-028 SHALL: macro BRAM_COPY_CHECKSUM_EN defined adds output checksum (BITWIDTH) = mod-2^BITWIDTH sum of every DST_WRDATA written; cleared on start accept, stable from FIN until next start, 0 on reset.
REQ-029 SHALL: without BRAM_COPY_CHECKSUM_EN, checksum port and adder be absent; all other behaviour identical.

Verification
REQ-030 SHALL: src_base=0, dst_base=0, len=8192, source holds word i = i -> destination word i = i for all i; done at cycle 8194; busy cycles 1..8193.
REQ-031 SHALL: len=0 -> no SRC_EN/DST_EN activity; done=1 in cycle 1; busy stays 0.
REQ-032 SHALL: src_base=0x7FF8, len=4 -> SRC_ADDR sequence 0x7FF8, 0x7FFC, 0x0000, 0x0004.
REQ-033 SHALL: start re-pulsed at cycle 3 of a len=10 copy -> ignored; exactly 10 writes, single done at cycle 12.
REQ-034 SHALL: BRAM_RST=0 at cycle 5 of a len=100 copy -> outputs 0 same cycle; destination words 4.. unwritten.
REQ-035 SHALL: with BRAM_COPY_CHECKSUM_EN, source words 1,2,3,0xFFFFFFFF, len=4 -> checksum=0x00000005 at done.
